// File: rtl/timestamp_gate.sv
// timestamp_gate: holds each packet's payload until the sample-time counter reaches the header timestamp
//   Optional macro TIMESTAMP_GATE_LATE_DROP_EN: late packets are discarded instead of streamed.
//   clk, resetn                 sole clock, synchronous active-low reset
//   enable_count                enabled channel count, sampled with each header beat
//   sample_tick                 one pulse per DAC sample period
//   time_load, time_load_value  overwrite the sample-time counter (wins over sample_tick)
//   s_axis_*                    upstream stream; first beat of each packet carries the timestamp
//   m_axis_*                    payload, zero-latency pass-through while streaming
//   sample_time                 current sample-time counter
//   late, underflow, cfg_error  registered one-cycle status pulses
module timestamp_gate #(
   parameter int NUM_OF_CHANNELS     = 4,
   parameter int SAMPLES_PER_CHANNEL = 1,
   parameter int SAMPLE_DATA_WIDTH   = 16,
   parameter int TIMESTAMP_WIDTH     = 64,
   localparam int DATA_WIDTH = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH,
   localparam int EC_W       = $clog2(NUM_OF_CHANNELS + 1)
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [EC_W-1:0]            enable_count,
   input  logic                       sample_tick,
   input  logic                       time_load,
   input  logic [TIMESTAMP_WIDTH-1:0] time_load_value,
   input  logic                       s_axis_valid,
   output logic                       s_axis_ready,
   input  logic [DATA_WIDTH-1:0]      s_axis_data,
   input  logic                       s_axis_last,
   output logic                       m_axis_valid,
   input  logic                       m_axis_ready,
   output logic [DATA_WIDTH-1:0]      m_axis_data,
   output logic                       m_axis_last,
   output logic [TIMESTAMP_WIDTH-1:0] sample_time,
   output logic                       late,
   output logic                       underflow,
   output logic                       cfg_error
);
   localparam int SPB_MAX = $clog2(NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL);
   localparam int LOG_W   = $clog2(SPB_MAX + 2);
   localparam int CW      = SPB_MAX + 8;
   typedef enum logic [1:0] {IDLE, WAIT, STREAM, DROP} state_e;
`ifdef TIMESTAMP_GATE_LATE_DROP_EN
   localparam state_e LATE_NEXT = DROP;
`else
   localparam state_e LATE_NEXT = STREAM;
`endif
   state_e state_q, state_d;
   logic [TIMESTAMP_WIDTH-1:0] sample_time_q, sample_time_d, ts_q, ts_d, ts_hdr;
   logic [LOG_W-1:0] spb_log2_q, spb_log2_d, ec_log2;
   logic [CW-1:0] credit_q, credit_d;
   logic [CW:0] credit_sum;
   logic late_q, late_d, underflow_q, underflow_d, cfg_error_q, cfg_error_d;
   logic ec_ok, rdy, fwd, take;
   assign ts_hdr        = s_axis_data[TIMESTAMP_WIDTH-1:0];
   assign ec_ok         = enable_count != '0 && (enable_count & (enable_count - EC_W'(1))) == '0
                          && enable_count <= EC_W'(NUM_OF_CHANNELS);
   assign fwd           = resetn && state_q == STREAM;
   assign s_axis_ready  = resetn && rdy;
   assign m_axis_valid  = fwd && s_axis_valid;
   assign m_axis_last   = fwd && s_axis_last;
   assign m_axis_data   = s_axis_data;
   assign take          = s_axis_valid && s_axis_ready;
   assign sample_time_d = time_load ? time_load_value : sample_time_q + TIMESTAMP_WIDTH'(sample_tick);
   // a beat arriving together with a tick covers that tick, so it never counts as underflow
   assign credit_sum    = {1'b0, credit_q}
                        + (fwd && take ? (CW+1)'(1) << spb_log2_q : '0)
                        - (CW+1)'(sample_tick && credit_q != '0 && state_q != DROP);
   assign credit_d      = credit_sum[CW] ? '1 : credit_sum[CW-1:0];
   assign underflow_d   = fwd && sample_tick && credit_q == '0 && !take;
   assign sample_time   = sample_time_q;
   assign late          = late_q;
   assign underflow     = underflow_q;
   assign cfg_error     = cfg_error_q;
   always_comb begin
      ec_log2 = '0;
      for (int i = 0; i < EC_W; i++) ec_log2 = enable_count[i] ? LOG_W'(i) : ec_log2;
   end
   always_comb begin
      state_d     = state_q;
      ts_d        = ts_q;
      spb_log2_d  = spb_log2_q;
      late_d      = 1'b0;
      cfg_error_d = 1'b0;
      rdy         = 1'b0;
      case (state_q)
         IDLE: begin
            rdy = 1'b1;
            if (s_axis_valid) begin
               ts_d        = ts_hdr;
               spb_log2_d  = ec_ok ? LOG_W'(SPB_MAX) - ec_log2 : '0;
               cfg_error_d = !ec_ok;
               late_d      = !s_axis_last && !(&ts_hdr) && ts_hdr < sample_time_q;
               state_d     = s_axis_last ? IDLE : &ts_hdr ? STREAM : late_d ? LATE_NEXT : WAIT;
            end
         end
         WAIT: begin
            late_d  = sample_time_q != ts_q && time_load && time_load_value > ts_q;
            state_d = sample_time_q == ts_q ? STREAM : late_d ? LATE_NEXT : WAIT;
         end
         STREAM: begin
            rdy     = m_axis_ready;
            state_d = s_axis_valid && m_axis_ready && s_axis_last ? IDLE : STREAM;
         end
         default: begin
            rdy     = 1'b1;
            state_d = s_axis_valid && s_axis_last ? IDLE : DROP;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= IDLE;
         sample_time_q <= '0;
         ts_q          <= '0;
         spb_log2_q    <= '0;
         credit_q      <= '0;
         late_q        <= 1'b0;
         underflow_q   <= 1'b0;
         cfg_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sample_time_q <= sample_time_d;
         ts_q          <= ts_d;
         spb_log2_q    <= spb_log2_d;
         credit_q      <= credit_d;
         late_q        <= late_d;
         underflow_q   <= underflow_d;
         cfg_error_q   <= cfg_error_d;
      end
   end
endmodule

// File: tb/tb_timestamp_gate.sv
// tb_timestamp_gate: randomized scoreboard bench for timestamp_gate against a sample-level reference model
module tb_timestamp_gate;
   localparam logic [63:0] ALL1 = '1;
`ifdef TIMESTAMP_GATE_LATE_DROP_EN
   localparam int LATE_MD = 3;
`else
   localparam int LATE_MD = 2;
`endif
   typedef struct packed {logic [63:0] d; logic l;} beat_t;
   logic clk = 1'b0, resetn = 1'b0, sample_tick = 1'b0, time_load = 1'b0;
   logic [2:0] enable_count = 3'd4;
   logic [63:0] time_load_value = '0, s_axis_data = '0, m_axis_data, sample_time;
   logic s_axis_valid = 1'b0, s_axis_last = 1'b0, m_axis_ready = 1'b1;
   logic s_axis_ready, m_axis_valid, m_axis_last, late, underflow, cfg_error;
   int errors = 0, checks = 0;
   int tick_mode = 1, mr_mode = 1, tl_mode = 0;
   logic tl_force = 1'b0;
   logic [63:0] tl_val = '0;
   int late_cnt = 0, uf_cnt = 0, cfg_cnt = 0, beat_cnt = 0;
   beat_t exp_q[$];
   int md = 0;
   longint unsigned m_st = 0, m_ts = 0;
   int m_credit = 0, m_spb = 1;
   logic m_late = 1'b0, m_uf = 1'b0, m_cfg = 1'b0;

   timestamp_gate dut (
      .clk(clk), .resetn(resetn), .enable_count(enable_count), .sample_tick(sample_tick),
      .time_load(time_load), .time_load_value(time_load_value),
      .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready), .s_axis_data(s_axis_data),
      .s_axis_last(s_axis_last), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_last(m_axis_last), .sample_time(sample_time),
      .late(late), .underflow(underflow), .cfg_error(cfg_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [63:0] d, input logic l);
      int n;
      n = 0;
      s_axis_valid = 1'b1;
      s_axis_data = d;
      s_axis_last = l;
      @(negedge clk);
      while (!s_axis_ready) begin
         if (n++ > 500) begin
            checks++;
            errors++;
            $display("FAIL handshake: s_axis_ready stuck at %0b for 500 cycles, expected 1", s_axis_ready);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      s_axis_valid = 1'b0;
   endtask

   task automatic pkt(input logic [63:0] ts, input int n, input int gap);
      send(ts, n == 0);
      for (int i = 0; i < n; i++) begin
         if (gap > 0) idle($urandom_range(0, gap));
         send({$urandom, $urandom}, i == n - 1);
      end
   endtask

   // background inputs: ticks, downstream ready and time loads
   initial forever begin
      @(posedge clk);
      #2;
      sample_tick = tick_mode == 1 ? 1'b1 : tick_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      m_axis_ready = mr_mode == 1 ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (tl_mode == 1 && $urandom_range(0, 19) == 0) begin
         time_load = 1'b1;
         time_load_value = (sample_time > 64'd5 ? sample_time - 64'd5 : sample_time) + 64'($urandom_range(0, 35));
      end else begin
         time_load = tl_force;
         time_load_value = tl_val;
      end
   end

   // reference model: per-cycle view of the packet rules, expected beats go to the scoreboard
   always @(negedge clk) begin
      int pm;
      logic rdy, acc;
      chk("sample_time", sample_time, m_st);
      chk("late", late, m_late);
      chk("underflow", underflow, m_uf);
      chk("cfg_error", cfg_error, m_cfg);
      rdy = resetn && (md == 0 || md == 3 || (md == 2 && m_axis_ready));
      chk("s_axis_ready", s_axis_ready, rdy);
      chk("m_axis_valid", m_axis_valid, resetn && md == 2 && s_axis_valid);
      acc = rdy && s_axis_valid;
      if (acc && md == 2) exp_q.push_back({s_axis_data, s_axis_last});
      m_late = 1'b0;
      m_uf = 1'b0;
      m_cfg = 1'b0;
      pm = md;
      if (!resetn) begin
         md = 0;
         m_st = 0;
         m_credit = 0;
      end else begin
         case (md)
            0: if (acc) begin
               m_ts = s_axis_data;
               m_cfg = !(enable_count inside {1, 2, 4});
               m_spb = m_cfg ? 1 : 4 / int'(enable_count);
               if (s_axis_last) md = 0;
               else if (m_ts == ALL1) md = 2;
               else if (m_ts < m_st) begin
                  m_late = 1'b1;
                  md = LATE_MD;
               end else md = 1;
            end
            1: if (m_st == m_ts) md = 2;
               else if (time_load && time_load_value > m_ts) begin
                  m_late = 1'b1;
                  md = LATE_MD;
               end
            2: begin
               if (sample_tick && m_credit == 0 && !acc) m_uf = 1'b1;
               m_credit = m_credit + (acc ? m_spb : 0) - ((sample_tick && m_credit > 0) ? 1 : 0);
               if (m_credit > 1023) m_credit = 1023;
               if (acc && s_axis_last) md = 0;
            end
            default: if (acc && s_axis_last) md = 0;
         endcase
         if ((pm == 0 || pm == 1) && sample_tick && m_credit > 0) m_credit--;
         m_st = time_load ? time_load_value : sample_tick ? m_st + 1 : m_st;
      end
   end

   // monitor: pops the scoreboard whenever the DUT hands a beat downstream
   always @(negedge clk) begin
      beat_t b;
      #1;
      if (late) late_cnt++;
      if (underflow) uf_cnt++;
      if (cfg_error) cfg_cnt++;
      if (m_axis_valid && m_axis_ready) begin
         beat_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL m_axis beat: got data %0h last %0b, expected no beat", m_axis_data, m_axis_last);
         end else begin
            b = exp_q.pop_front();
            chk("m_axis_data", m_axis_data, b.d);
            chk("m_axis_last", m_axis_last, b.l);
         end
      end
   end

   initial begin
      int l0, u0, c0, b0, kind;
      logic [63:0] t;
      repeat (3) @(posedge clk);
      #1;
      chk("reset sample_time", sample_time, 0);
      chk("reset s_axis_ready", s_axis_ready, 0);
      chk("reset m_axis_valid", m_axis_valid, 0);
      resetn = 1'b1;
      pkt(64'd10, 3, 0);
      idle(5);
      chk("t1 late pulses", late_cnt, 0);
      chk("t1 underflow pulses", uf_cnt, 0);
      chk("t1 cfg pulses", cfg_cnt, 0);
      chk("t1 beats out", beat_cnt, 3);
      l0 = late_cnt;
      b0 = beat_cnt;
      tl_val = 64'd100;
      tl_force = 1'b1;
      idle(1);
      tl_force = 1'b0;
      pkt(64'd50, 2, 0);
      idle(3);
      chk("t2 late pulses", late_cnt - l0, 1);
      chk("t2 beats out", beat_cnt - b0, LATE_MD == 2 ? 2 : 0);
      idle(10);
      u0 = uf_cnt;
      l0 = late_cnt;
      enable_count = 3'd1;
      send(ALL1, 1'b0);
      send({$urandom, $urandom}, 1'b0);
      idle(5);
      send({$urandom, $urandom}, 1'b1);
      idle(3);
      chk("t3 underflow pulses", uf_cnt - u0, 1);
      chk("t3 late pulses", late_cnt - l0, 0);
      c0 = cfg_cnt;
      u0 = uf_cnt;
      enable_count = 3'd3;
      pkt(sample_time + 64'd5, 2, 0);
      idle(3);
      chk("t4 cfg pulses", cfg_cnt - c0, 1);
      chk("t4 underflow pulses", uf_cnt - u0, 0);
      b0 = beat_cnt;
      enable_count = 3'd4;
      send(sample_time + 64'd3, 1'b1);
      idle(4);
      chk("t5 empty packet beats", beat_cnt - b0, 0);
      send(sample_time + 64'd40, 1'b0);
      idle(3);
      resetn = 1'b0;
      idle(1);
      chk("wait reset sample_time", sample_time, 0);
      chk("wait reset s_axis_ready", s_axis_ready, 0);
      chk("wait reset m_axis_valid", m_axis_valid, 0);
      chk("wait reset pulses", {late, underflow, cfg_error, m_axis_last}, 0);
      resetn = 1'b1;
      send(ALL1, 1'b0);
      send({$urandom, $urandom}, 1'b0);
      resetn = 1'b0;
      idle(2);
      chk("stream reset sample_time", sample_time, 0);
      chk("stream reset m_axis_valid", m_axis_valid, 0);
      resetn = 1'b1;
      b0 = beat_cnt;
      pkt(sample_time + 64'd3, 2, 0);
      idle(3);
      chk("post reset beats out", beat_cnt - b0, 2);
      tick_mode = 0;
      mr_mode = 0;
      tl_mode = 1;
      for (int k = 0; k < 60; k++) begin
         kind = $urandom_range(0, 5);
         enable_count = 3'($urandom_range(0, 7));
         t = kind == 0 ? ALL1 : (kind == 1 && sample_time > 64'd60) ? sample_time - 64'($urandom_range(1, 50))
                                                                   : sample_time + 64'($urandom_range(1, 25));
         pkt(t, kind == 2 ? 0 : $urandom_range(1, 6), 2);
         idle($urandom_range(0, 3));
      end
      tl_mode = 0;
      tick_mode = 1;
      idle(20);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
